sdram_arb: RTL and testbench

Two-master arbiter that sits directly upstream of the simulated SDRAM port and drives its `cpu_*` request interface. Port 0 is the instruction-fetch master (burst reads only); port 1 is the data master (single/burst reads, single writes with byte enables). The arbiter serialises requests, issues exactly one single-cycle `rd`/`we` strobe per transaction, counts returned beats, and routes read data back to the owning master.

---
 rtl/sdram_arb.sv | 171 +++++++++++++++++
 tb/tb_sdram_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arb
//  Function : Two-master arbiter driving the SDRAM cpu request port. Port 0 is
//             instruction fetch (burst reads), port 1 is data (reads/writes).
//             Define SDRAM_ARB_RR_EN for round-robin arbitration; otherwise
//             port 1 has fixed priority over port 0.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_arb #(
    parameter int AW  = 32,
    parameter int BCW = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           p0_req,
    input  logic [AW-1:0]  p0_addr,
    input  logic [BCW-1:0] p0_burstcount,
    output logic           p0_accept,
    output logic           p0_rvalid,
    output logic           p0_done,
    input  logic           p1_req,
    input  logic           p1_we,
    input  logic [AW-1:0]  p1_addr,
    input  logic [31:0]    p1_wdata,
    input  logic [3:0]     p1_be,
    input  logic [BCW-1:0] p1_burstcount,
    output logic           p1_accept,
    output logic           p1_rvalid,
    output logic           p1_done,
    output logic [31:0]    rdata,
    output logic [AW-1:0]  mem_addr,
    output logic [31:0]    mem_din,
    output logic [3:0]     mem_be,
    output logic [BCW-1:0] mem_burstcount,
    output logic           mem_rd,
    output logic           mem_we,
    input  logic           mem_busy,
    input  logic [31:0]    mem_dout,
    input  logic           mem_dout_ready
);

    localparam logic [BCW-1:0] c_BC_ONE = BCW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_owner;
    logic           r_first;
    logic [BCW-1:0] r_beats_left;

    logic           w_grant_any;
    logic           w_grant_port;
    logic [BCW-1:0] w_p0_bc;
    logic [BCW-1:0] w_p1_bc;
    logic           w_beat;
    logic [BCW-1:0] w_beats_next;
    logic           w_complete;

`ifdef SDRAM_ARB_RR_EN
    // Port favoured on a tie; points away from the most recent grant.
    logic r_rr_ptr;

    always_comb begin
        w_grant_any  = p0_req | p1_req;
        w_grant_port = (p0_req && p1_req) ? r_rr_ptr : p1_req;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= 1'b0;
        end else if (r_state == S_IDLE && w_grant_any) begin
            r_rr_ptr <= ~w_grant_port;
        end
    end
`else
    always_comb begin
        w_grant_any  = p0_req | p1_req;
        w_grant_port = p1_req;
    end
`endif

    assign w_p0_bc = (p0_burstcount == '0) ? c_BC_ONE : p0_burstcount;
    assign w_p1_bc = (p1_we || p1_burstcount == '0) ? c_BC_ONE : p1_burstcount;

    // Beats beyond the requested count are dropped, never forwarded.
    assign w_beat       = mem_dout_ready && (r_state == S_WAIT) && (r_beats_left != '0);
    assign w_beats_next = r_beats_left - {{(BCW-1){1'b0}}, w_beat};
    // Busy lags the strobe by a cycle, so the first WAIT cycle cannot complete.
    assign w_complete   = (r_state == S_WAIT) && !r_first && (w_beats_next == '0) && !mem_busy;

    assign p0_rvalid = w_beat && !r_owner;
    assign p1_rvalid = w_beat &&  r_owner;
    assign p0_done   = w_complete && !r_owner;
    assign p1_done   = w_complete &&  r_owner;
    assign rdata     = mem_dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_owner        <= 1'b0;
            r_first        <= 1'b0;
            r_beats_left   <= '0;
            mem_addr       <= '0;
            mem_din        <= '0;
            mem_be         <= '0;
            mem_burstcount <= '0;
            mem_rd         <= 1'b0;
            mem_we         <= 1'b0;
            p0_accept      <= 1'b0;
            p1_accept      <= 1'b0;
        end else begin
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            p0_accept <= 1'b0;
            p1_accept <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_owner <= w_grant_port;
                        r_state <= S_ISSUE;
                        if (w_grant_port) begin
                            mem_addr       <= p1_addr;
                            mem_din        <= p1_wdata;
                            mem_be         <= p1_be;
                            mem_burstcount <= w_p1_bc;
                            r_beats_left   <= p1_we ? '0 : w_p1_bc;
                            mem_rd         <= ~p1_we;
                            mem_we         <= p1_we;
                            p1_accept      <= 1'b1;
                        end else begin
                            mem_addr       <= p0_addr;
                            mem_din        <= '0;
                            mem_be         <= 4'hF;
                            mem_burstcount <= w_p0_bc;
                            r_beats_left   <= w_p0_bc;
                            mem_rd         <= 1'b1;
                            p0_accept      <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_first <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_first      <= 1'b0;
                    r_beats_left <= w_beats_next;
                    if (w_complete) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n && r_state == S_WAIT && mem_dout_ready && r_beats_left == '0) begin
            $error("sdram_arb: read beat received with no beats outstanding");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_arb
//  Function : Scoreboard bench for sdram_arb: randomised masters, reactive
//             memory responder and an arbitration reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_arb;

    localparam int AW  = 32;
    localparam int BCW = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           p0_req, p0_accept, p0_rvalid, p0_done;
    logic [AW-1:0]  p0_addr;
    logic [BCW-1:0] p0_burstcount;
    logic           p1_req, p1_we, p1_accept, p1_rvalid, p1_done;
    logic [AW-1:0]  p1_addr;
    logic [31:0]    p1_wdata;
    logic [3:0]     p1_be;
    logic [BCW-1:0] p1_burstcount;
    logic [31:0]    rdata;
    logic [AW-1:0]  mem_addr;
    logic [31:0]    mem_din;
    logic [3:0]     mem_be;
    logic [BCW-1:0] mem_burstcount;
    logic           mem_rd, mem_we, mem_busy, mem_dout_ready;
    logic [31:0]    mem_dout;

    sdram_arb #(.AW(AW), .BCW(BCW)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_burstcount(p0_burstcount),
        .p0_accept(p0_accept), .p0_rvalid(p0_rvalid), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_be(p1_be), .p1_burstcount(p1_burstcount),
        .p1_accept(p1_accept), .p1_rvalid(p1_rvalid), .p1_done(p1_done),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
        .mem_burstcount(mem_burstcount), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_busy(mem_busy), .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr; logic [7:0] bc; logic we; logic [31:0] wdata; logic [3:0] be; int gap;
    } txn_t;
    typedef struct {
        int port; logic [31:0] addr; logic [7:0] bc; logic we; logic [31:0] din; logic [3:0] be;
    } cmd_t;
    typedef struct { int port; int cyc; } done_t;

    txn_t        q0[$], q1[$];
    cmd_t        exp_cmd[$];
    done_t       exp_done[$];
    logic [31:0] exp_beat0[$], exp_beat1[$];
    cmd_t        cur;

    int n_chk = 0, n_err = 0, cyc = 0, force_extra = -1, p0_beats_seen = 0;
    bit cmd_pending = 0, resp_active = 0, abort = 0;
`ifdef SDRAM_ARB_RR_EN
    int last_grant = -1;
`endif

    logic           prev_p0_req, prev_p1_req, prev_p1_we;
    logic [31:0]    prev_p0_addr, prev_p1_addr, prev_p1_wdata;
    logic [7:0]     prev_p0_bc, prev_p1_bc;
    logic [3:0]     prev_p1_be;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic [7:0] bc, input logic we,
                                input logic [31:0] wd, input logic [3:0] be, input int gap);
        txn_t t;
        t.addr = a; t.bc = bc; t.we = we; t.wdata = wd; t.be = be; t.gap = gap;
        return t;
    endfunction

    // Expected winner from the requests held during the IDLE cycle.
    function automatic int arb(input logic r0, input logic r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
`ifdef SDRAM_ARB_RR_EN
        return (last_grant == 0) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    task automatic check_all_zero(input string name);
        check(name, {p0_accept, p0_rvalid, p0_done, p1_accept, p1_rvalid, p1_done, mem_rd, mem_we,
                     |mem_addr, |mem_din, |mem_be, |mem_burstcount}, 0);
    endtask

    // Monitor / scoreboard
    initial begin : mon
        int ep; cmd_t c; done_t d; logic [31:0] b;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
`ifdef SDRAM_ARB_RR_EN
                last_grant = -1;
`endif
                prev_p0_req = 0; prev_p1_req = 0;
            end else begin
                if (p0_accept || p1_accept) begin
                    ep = arb(prev_p0_req, prev_p1_req);
                    check("accept_port", (p0_accept && p1_accept) ? 2 : (p1_accept ? 1 : 0), ep);
                    if (ep >= 0) begin
                        c.port = ep;
                        if (ep == 0) begin
                            c.addr = prev_p0_addr; c.we = 0; c.din = 0; c.be = 4'hF;
                            c.bc = (prev_p0_bc == 0) ? 8'd1 : prev_p0_bc;
                        end else begin
                            c.addr = prev_p1_addr; c.we = prev_p1_we; c.din = prev_p1_wdata; c.be = prev_p1_be;
                            c.bc = (prev_p1_we || prev_p1_bc == 0) ? 8'd1 : prev_p1_bc;
                        end
                        exp_cmd.push_back(c);
`ifdef SDRAM_ARB_RR_EN
                        last_grant = ep;
`endif
                    end
                end
                if (mem_rd || mem_we) begin
                    check("strobe_exclusive", mem_rd & mem_we, 0);
                    check("strobe_cmd_queued", exp_cmd.size() > 0, 1);
                    if (exp_cmd.size() > 0) begin
                        c = exp_cmd.pop_front();
                        check("cmd_we", mem_we, c.we);
                        check("cmd_addr", mem_addr, c.addr);
                        check("cmd_bc", mem_burstcount, c.bc);
                        if (c.we) begin
                            check("cmd_be", mem_be, c.be);
                            check("cmd_din", mem_din, c.din);
                        end
                        cur = c;
                        cmd_pending = 1;
                    end
                end
                if (p0_rvalid || p1_rvalid) check("rvalid_exclusive", p0_rvalid & p1_rvalid, 0);
                if (p0_rvalid) begin
                    p0_beats_seen++;
                    check("rvalid0_expected", exp_beat0.size() > 0, 1);
                    if (exp_beat0.size() > 0) begin
                        b = exp_beat0.pop_front();
                        check("rdata_p0", rdata, b);
                    end
                end
                if (p1_rvalid) begin
                    check("rvalid1_expected", exp_beat1.size() > 0, 1);
                    if (exp_beat1.size() > 0) begin
                        b = exp_beat1.pop_front();
                        check("rdata_p1", rdata, b);
                    end
                end
                if (p0_done || p1_done) begin
                    check("done_exclusive", p0_done & p1_done, 0);
                    check("done_expected", exp_done.size() > 0, 1);
                    if (exp_done.size() > 0) begin
                        d = exp_done.pop_front();
                        check("done_port", p1_done, d.port);
                        check("done_cycle", cyc, d.cyc);
                    end
                end
                prev_p0_req = p0_req; prev_p0_addr = p0_addr; prev_p0_bc = p0_burstcount;
                prev_p1_req = p1_req; prev_p1_we = p1_we; prev_p1_addr = p1_addr;
                prev_p1_wdata = p1_wdata; prev_p1_be = p1_be; prev_p1_bc = p1_burstcount;
            end
        end
    end

    // Downstream memory: random beat pacing, busy held while beats remain plus a tail.
    initial begin : resp
        int rem, extra, k, idx; bit busy_now, rdy, fin, fields_ok; done_t d;
        forever begin
            @(posedge clk); #1;
            if (cmd_pending && !abort) begin
                resp_active = 1; cmd_pending = 0;
                rem = cur.we ? 0 : int'(cur.bc);
                extra = (force_extra >= 0) ? force_extra : int'($urandom_range(0, 3));
                k = 0; idx = 0; fin = 0; fields_ok = 1;
                forever begin
                    k++;
                    if (mem_addr !== cur.addr || mem_burstcount !== cur.bc) fields_ok = 0;
                    rdy = (rem > 0) && ($urandom_range(0, 3) != 0);
                    busy_now = (rem > 0) || (extra > 0);
                    mem_dout = $urandom;
                    if (rdy) begin
                        mem_dout = (32'hDEADBEEF ^ cur.addr ^ 32'h0000_1000) + 32'(idx * 4);
                        if (cur.port == 0) exp_beat0.push_back(mem_dout);
                        else               exp_beat1.push_back(mem_dout);
                        idx++; rem--;
                    end else if (rem == 0 && extra > 0) begin
                        extra--;
                    end
                    mem_dout_ready = rdy;
                    mem_busy = busy_now;
                    if (k >= 2 && rem == 0 && !busy_now) begin
                        d.port = cur.port; d.cyc = cyc;
                        exp_done.push_back(d);
                        fin = 1;
                    end
                    if (fin) break;
                    @(posedge clk); #1;
                    if (abort) break;
                end
                mem_dout_ready = 0;
                if (abort) mem_busy = 0;
                else check("mem_fields_stable", fields_ok, 1);
                resp_active = 0;
            end
        end
    end

    task automatic run_p0();
        txn_t t; bit got;
        while (q0.size() > 0) begin
            t = q0.pop_front();
            if (t.gap > 0) begin
                p0_req = 0;
                repeat (t.gap) begin @(posedge clk); #1; end
            end
            p0_req = 1; p0_addr = t.addr; p0_burstcount = t.bc;
            got = 0;
            for (int k = 0; k < 4000 && !got; k++) begin
                @(negedge clk);
                got = p0_accept;
            end
            check("p0_accept_seen", got, 1);
            @(posedge clk); #1;
        end
        p0_req = 0;
    endtask

    task automatic run_p1();
        txn_t t; bit got;
        while (q1.size() > 0) begin
            t = q1.pop_front();
            if (t.gap > 0) begin
                p1_req = 0;
                repeat (t.gap) begin @(posedge clk); #1; end
            end
            p1_req = 1; p1_addr = t.addr; p1_burstcount = t.bc;
            p1_we = t.we; p1_wdata = t.wdata; p1_be = t.be;
            got = 0;
            for (int k = 0; k < 4000 && !got; k++) begin
                @(negedge clk);
                got = p1_accept;
            end
            check("p1_accept_seen", got, 1);
            @(posedge clk); #1;
        end
        p1_req = 0;
    endtask

    task automatic drain();
        bit idle;
        idle = 0;
        for (int k = 0; k < 500 && !idle; k++) begin
            @(negedge clk);
            idle = !cmd_pending && !resp_active && exp_done.size() == 0 && exp_cmd.size() == 0;
        end
        check("drain_idle", idle, 1);
        @(posedge clk); #1;
    endtask

    initial begin : main
        txn_t t; bit ok;
        reset_n = 0;
        p0_req = 0; p0_addr = 0; p0_burstcount = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0; p1_burstcount = 0;
        mem_busy = 0; mem_dout = 0; mem_dout_ready = 0;
        repeat (3) begin @(posedge clk); #1; end
        check_all_zero("reset_outputs");
        reset_n = 1;
        @(posedge clk); #1;

        q1.push_back(mk(32'h1000, 8'd1, 1'b0, 32'h0, 4'hF, 0));
        run_p1(); drain();

        q0.push_back(mk(32'h2000, 8'd8, 1'b0, 32'h0, 4'hF, 0));
        run_p0(); drain();

        force_extra = 3;
        q1.push_back(mk(32'h3000, 8'd5, 1'b1, 32'hCAFEF00D, 4'b0110, 0));
        run_p1(); drain();
        force_extra = -1;

        q0.push_back(mk(32'h4000, 8'd0, 1'b0, 32'h0, 4'hF, 0));
        run_p0(); drain();

        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(32'h5000 + 32'(i * 16), 8'd2, 1'b0, 32'h0, 4'hF, 0));
            q1.push_back(mk(32'h6000 + 32'(i * 16), 8'd1, 1'(i % 2), $urandom, 4'hF, 0));
        end
        fork run_p0(); run_p1(); join
        drain();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                q0.push_back(mk($urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 8)), 1'b0, 32'h0, 4'hF,
                                int'($urandom_range(0, 3))));
            else
                q1.push_back(mk($urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                                $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3))));
        end
        fork run_p0(); run_p1(); join
        drain();

        p0_beats_seen = 0;
        q0.push_back(mk(32'h7000, 8'd8, 1'b0, 32'h0, 4'hF, 0));
        run_p0();
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk); #1;
            ok = (p0_beats_seen >= 3);
        end
        check("mid_burst_three_beats", ok, 1);
        #1;
        abort = 1;
        reset_n = 0;
        #1;
        check_all_zero("async_reset_outputs");
        repeat (3) begin @(posedge clk); #1; end
        check_all_zero("reset_held_outputs");
        exp_cmd.delete(); exp_done.delete(); exp_beat0.delete(); exp_beat1.delete();
        cmd_pending = 0; mem_busy = 0; mem_dout_ready = 0;
        abort = 0;
        reset_n = 1;
        @(posedge clk); #1;

        q1.push_back(mk(32'h1000, 8'd1, 1'b0, 32'h0, 4'hF, 0));
        run_p1(); drain();

        check("leftover_beats", exp_beat0.size() + exp_beat1.size(), 0);
        check("leftover_cmds", exp_cmd.size() + exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
